// File: rtl/direct_line_sequencer.sv
// Direct line-state sequencer for the host TX port: arbitrates, then writes
// direct or timed line states, closing every session with one idle write.
`ifndef TX_DIRECT_CONTROL
`define TX_DIRECT_CONTROL 8'h00
`endif
`ifndef TX_IDLE
`define TX_IDLE 8'h03
`endif

module direct_line_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int LINE_WIDTH = 2,
  parameter int CNT_WIDTH  = 16,
  parameter logic [DATA_WIDTH-1:0] CNTL_DIRECT = `TX_DIRECT_CONTROL,
  parameter logic [DATA_WIDTH-1:0] CNTL_IDLE   = `TX_IDLE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  directControlEn,
  input  logic [LINE_WIDTH-1:0] directControlLineState,
  input  logic                  timedStart,
  input  logic [LINE_WIDTH-1:0] timedLineState,
  input  logic [CNT_WIDTH-1:0]  timedCount,
  output logic                  timedBusy,
  output logic                  timedDone,
  input  logic                  HCTxPortGnt,
  input  logic                  HCTxPortRdy,
  output logic                  HCTxPortReq,
  output logic                  HCTxPortWEn,
  output logic [DATA_WIDTH-1:0] HCTxPortData,
  output logic [DATA_WIDTH-1:0] HCTxPortCntl
);

  typedef enum logic [3:0] {
    START, CHK, D_GNT, D_RDY, D_LOOP, T_GNT, T_RDY, T_LOOP,
    I_GNT, I_RDY, I_FIN, DONE
  } state_t;

  state_t                state, stateNext;
  logic [CNT_WIDTH-1:0]  cnt, cntNext;
  logic [LINE_WIDTH-1:0] tLine, tLineNext;
  logic                  reqNext, wenNext, busyNext, doneNext;
  logic [DATA_WIDTH-1:0] dataNext, cntlNext;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= START;
      cnt          <= '0;
      tLine        <= '0;
      HCTxPortReq  <= 1'b0;
      HCTxPortWEn  <= 1'b0;
      HCTxPortData <= '0;
      HCTxPortCntl <= '0;
      timedBusy    <= 1'b0;
      timedDone    <= 1'b0;
    end else begin
      state        <= stateNext;
      cnt          <= cntNext;
      tLine        <= tLineNext;
      HCTxPortReq  <= reqNext;
      HCTxPortWEn  <= wenNext;
      HCTxPortData <= dataNext;
      HCTxPortCntl <= cntlNext;
      timedBusy    <= busyNext;
      timedDone    <= doneNext;
    end
  end

  // Outputs are computed one state ahead so every port comes straight off a flop.
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    tLineNext = tLine;
    reqNext   = HCTxPortReq;
    wenNext   = 1'b0;
    dataNext  = HCTxPortData;
    cntlNext  = HCTxPortCntl;
    busyNext  = timedBusy;
    doneNext  = 1'b0;
    case (state)
      START: begin
        reqNext   = 1'b1;
        stateNext = I_GNT;
      end
      CHK: begin
        if (timedStart) begin
          tLineNext = timedLineState;
          cntNext   = (timedCount == '0) ? CNT_WIDTH'(1) : timedCount;
          busyNext  = 1'b1;
          reqNext   = 1'b1;
          stateNext = T_GNT;
        end else if (directControlEn) begin
          reqNext   = 1'b1;
          stateNext = D_GNT;
        end else begin
          reqNext   = 1'b0;
        end
      end
      D_GNT: if (HCTxPortGnt) stateNext = D_RDY;
      D_RDY: begin
        if (HCTxPortRdy) begin
          wenNext   = 1'b1;
          dataNext  = DATA_WIDTH'(directControlLineState);
          cntlNext  = CNTL_DIRECT;
          stateNext = D_LOOP;
        end
      end
      // Falling out of direct mode keeps the grant and goes straight to the idle write.
      D_LOOP: stateNext = directControlEn ? D_RDY : I_RDY;
      T_GNT: if (HCTxPortGnt) stateNext = T_RDY;
      T_RDY: begin
        if (HCTxPortRdy) begin
          wenNext   = 1'b1;
          dataNext  = DATA_WIDTH'(tLine);
          cntlNext  = CNTL_DIRECT;
          cntNext   = cnt - CNT_WIDTH'(1);
          stateNext = T_LOOP;
        end
      end
      T_LOOP: stateNext = (cnt != '0) ? T_RDY : I_RDY;
      I_GNT: if (HCTxPortGnt) stateNext = I_RDY;
      I_RDY: begin
        if (HCTxPortRdy) begin
          wenNext   = 1'b1;
          dataNext  = '0;
          cntlNext  = CNTL_IDLE;
          stateNext = I_FIN;
        end
      end
      I_FIN: begin
        reqNext   = 1'b0;
        stateNext = timedBusy ? DONE : CHK;
      end
      DONE: begin
        doneNext  = 1'b1;
        busyNext  = 1'b0;
        stateNext = CHK;
      end
      default: stateNext = START;
    endcase
  end

endmodule

// File: tb/tb_direct_line_sequencer.sv
// Scoreboard bench: stimulus queues expected TX writes, a negedge monitor
// pops and compares on every WEn pulse and tracks timedDone pulses.
module tb_direct_line_sequencer;
  localparam int DW = 8, LW = 2, CW = 16;
  localparam logic [DW-1:0] CD = 8'hA5, CI = 8'h3C;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [DW-1:0] cntl;
    logic          busy;
  } wr_t;

  logic clk = 0, rst = 1, en = 0, tStart = 0, gnt = 1, rdy = 1;
  logic [LW-1:0] dLine = '0, tLine = '0;
  logic [CW-1:0] tCount = '0;
  logic busy, done, req, wen;
  logic [DW-1:0] data, cntl;

  wr_t sbQ[$];
  int errors = 0, checks = 0, writesSeen = 0, doneSeen = 0, expDone = 0;
  logic lastRdy = 0, lastWen = 0, lastDone = 0;

  direct_line_sequencer #(.DATA_WIDTH(DW), .LINE_WIDTH(LW), .CNT_WIDTH(CW),
    .CNTL_DIRECT(CD), .CNTL_IDLE(CI)) dut (
    .clk(clk), .rst(rst), .directControlEn(en), .directControlLineState(dLine),
    .timedStart(tStart), .timedLineState(tLine), .timedCount(tCount),
    .timedBusy(busy), .timedDone(done), .HCTxPortGnt(gnt), .HCTxPortRdy(rdy),
    .HCTxPortReq(req), .HCTxPortWEn(wen), .HCTxPortData(data), .HCTxPortCntl(cntl));

  always #5 clk = ~clk;

  // Monitor
  always @(negedge clk) begin
    wr_t e;
    if (wen) begin
      checks++;
      if (!lastRdy || lastWen) begin
        errors++;
        $display("FAIL wen_timing: rdyPrev=%0b wenPrev=%0b required rdyPrev=1 wenPrev=0", lastRdy, lastWen);
      end
      checks++;
      if (sbQ.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: data=%0h cntl=%0h busy=%0b, none required", data, cntl, busy);
      end else begin
        e = sbQ.pop_front();
        if ({data, cntl, busy} !== e) begin
          errors++;
          $display("FAIL write%0d: data=%0h cntl=%0h busy=%0b required data=%0h cntl=%0h busy=%0b",
                   writesSeen, data, cntl, busy, e.data, e.cntl, e.busy);
        end
      end
      writesSeen++;
    end
    if (done) begin
      doneSeen++;
      checks++;
      if (lastDone || busy) begin
        errors++;
        $display("FAIL done_pulse: prevDone=%0b busy=%0b required 0 0", lastDone, busy);
      end
    end
    lastRdy = rdy; lastWen = wen; lastDone = done;
  end

  task automatic checkEq(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [DW-1:0] d, input logic [DW-1:0] c, input logic b, input int n);
    wr_t e;
    e.data = d; e.cntl = c; e.busy = b;
    for (int i = 0; i < n; i++) sbQ.push_back(e);
  endtask

  task automatic waitWrites(input int target, input string nm);
    int n = 0;
    while (writesSeen < target && n < 500) begin @(posedge clk); n++; end
    #1;
    if (writesSeen < target) checkEq({nm, "_timeout"}, writesSeen, target);
  endtask

  task automatic endPhase(input string nm);
    int n = 0;
    while (sbQ.size() != 0 && n < 300) begin @(posedge clk); n++; end
    checkEq({nm, "_drain"}, sbQ.size(), 0);
    repeat (6) @(posedge clk);
    #1;
    checkEq({nm, "_req_idle"}, req, 0);
    checkEq({nm, "_busy_idle"}, busy, 0);
    checkEq({nm, "_done_count"}, doneSeen, expDone);
  endtask

  task automatic pulseStart(input logic [LW-1:0] ln, input logic [CW-1:0] c);
    tLine = ln; tCount = c; tStart = 1;
    tick();
    tStart = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, w, n;
    // Reset state and the single idle write after release
    repeat (3) @(posedge clk);
    #1;
    checkEq("rst_req", req, 0);
    checkEq("rst_wen", wen, 0);
    checkEq("rst_data", data, 0);
    checkEq("rst_cntl", cntl, 0);
    checkEq("rst_busy", busy, 0);
    checkEq("rst_done", done, 0);
    push(8'h00, CI, 0, 1);
    rst = 0;
    endPhase("post_reset");

    // Direct session with a line-state change, closed by one idle write
    base = writesSeen;
    push(8'h01, CD, 0, 3); push(8'h02, CD, 0, 2); push(8'h00, CI, 0, 1);
    dLine = 2'b01; en = 1;
    waitWrites(base + 3, "direct3");
    dLine = 2'b10;
    waitWrites(base + 4, "direct4");
    en = 0;
    endPhase("direct");

    // Timed session, count 5, line 00
    push(8'h00, CD, 1, 5); push(8'h00, CI, 1, 1); expDone++;
    pulseStart(2'b00, 16'd5);
    endPhase("timed5");

    // Count 0 behaves as 1
    push(8'h01, CD, 1, 1); push(8'h00, CI, 1, 1); expDone++;
    pulseStart(2'b01, 16'd0);
    endPhase("timed0");

    // Simultaneous start and direct enable: timed first, then direct
    base = writesSeen;
    push(8'h03, CD, 1, 2); push(8'h00, CI, 1, 1); expDone++;
    push(8'h01, CD, 0, 2); push(8'h00, CI, 0, 1);
    dLine = 2'b01; en = 1;
    pulseStart(2'b11, 16'd2);
    waitWrites(base + 4, "prio");
    en = 0;
    endPhase("priority");

    // Rdy stalls mid-session without changing the write count
    base = writesSeen;
    push(8'h02, CD, 1, 4); push(8'h00, CI, 1, 1); expDone++;
    pulseStart(2'b10, 16'd4);
    waitWrites(base + 2, "stall");
    rdy = 0;
    repeat (4) tick();
    rdy = 1;
    endPhase("rdy_stall");

    // Reset while in T_LOOP aborts without done or further writes
    push(8'h01, CD, 1, 2);
    pulseStart(2'b01, 16'd6);
    w = 0; n = 0;
    while (w < 2 && n < 200) begin @(negedge clk); n++; if (wen) w++; end
    checkEq("abort_reach", w, 2);
    rst = 1;
    @(negedge clk);
    checkEq("abort_req", req, 0);
    checkEq("abort_wen", wen, 0);
    checkEq("abort_data", data, 0);
    checkEq("abort_cntl", cntl, 0);
    checkEq("abort_busy", busy, 0);
    checkEq("abort_done", done, 0);
    repeat (4) @(negedge clk);
    checkEq("abort_no_done", doneSeen, expDone);
    checkEq("abort_queue", sbQ.size(), 0);
    push(8'h00, CI, 0, 1);
    @(posedge clk); #1;
    rst = 0;
    endPhase("abort");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/direct_line_sequencer.md
Name: direct_line_sequencer

Overview:
- Parametrised successor to the host controller's direct line-control FSM.
- Drives the host TX port arbitration handshake (Req/Gnt/Rdy/WEn) to write direct line states to the serial interface engine.
- Adds a timed mode: hold a line state for a programmed number of writes, then return to idle with a done pulse (USB reset, resume, SE0 signalling).
- Sits between the host controller register block and the TX port arbiter.

Parameters:
- DATA_WIDTH, 8: width of HCTxPortData and HCTxPortCntl.
- LINE_WIDTH, 2: width of line-state fields; zero-extended into HCTxPortData.
- CNT_WIDTH, 16: width of timedCount and the internal down-counter.
- CNTL_DIRECT, `TX_DIRECT_CONTROL: HCTxPortCntl code for direct line writes.
- CNTL_IDLE, `TX_IDLE: HCTxPortCntl code for idle writes.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- directControlEn  in  1  level; while high, continuously write directControlLineState.
- directControlLineState  in  LINE_WIDTH  line state for direct mode, sampled at each write.
- timedStart  in  1  single-cycle start of a timed session.
- timedLineState  in  LINE_WIDTH  line state for the timed session; latched on start.
- timedCount  in  CNT_WIDTH  number of timed writes; latched on start; 0 is treated as 1.
- timedBusy  out  1  high from the accepted start until timedDone.
- timedDone  out  1  one-cycle pulse at the end of a timed session.
- HCTxPortGnt  in  1  arbiter grant.
- HCTxPortRdy  in  1  TX port ready for a write.
- HCTxPortReq  out  1  arbiter request.
- HCTxPortWEn  out  1  one-cycle write strobe.
- HCTxPortData  out  DATA_WIDTH  {zeros, line state} for direct/timed writes; 0 for idle writes.
- HCTxPortCntl  out  DATA_WIDTH  CNTL_DIRECT or CNTL_IDLE.

Behaviour:
- All outputs are registered.
- Reset: every output is 0, counter is 0, state is START. Reset mid-session aborts at the next edge with no done pulse and no idle write.
- States: START, CHK, D_GNT, D_RDY, D_LOOP, T_GNT, T_RDY, T_LOOP, I_GNT, I_RDY, I_FIN, DONE.
- START -> I_GNT with Req=1. One idle write is issued after reset.
- CHK, priority timedStart > directControlEn > stay:
  - timedStart: latch line state and count (0 -> 1), timedBusy=1, Req=1, go to T_GNT.
  - directControlEn: Req=1, go to D_GNT.
  - Neither: remain in CHK with Req=0 and no writes.
- x_GNT -> x_RDY when Gnt=1.
- x_RDY with Rdy=1:
  - WEn=1 for the next cycle, with Data/Cntl loaded in the same cycle.
  - D_RDY -> D_LOOP; I_RDY -> I_FIN; T_RDY -> T_LOOP and the counter decrements.
- D_LOOP: WEn=0.
  - directControlEn=1 -> D_RDY.
  - Else -> I_RDY, keeping Req high with no re-arbitration; the idle write closes the session.
- T_LOOP: WEn=0.
  - Counter != 0 -> T_RDY.
  - Else -> I_RDY.
  - directControlEn is ignored during a timed session.
- I_FIN: WEn=0, Req=0.
  - If timedBusy -> DONE.
  - Else -> CHK.
- DONE: timedDone=1 for this one cycle, timedBusy=0, go to CHK.
- timedStart outside CHK is ignored and not queued.
- Data and Cntl hold their last value between writes.
- Minimum spacing between WEn pulses is 2 cycles.
- Latency:
  - CHK with a request -> Req high next cycle.
  - Rdy sampled high -> WEn high the following cycle.
- The block assumes Gnt is held while Req is high. Gnt deassertion mid-session does not change state.

Test Plan:
- Reset release, Gnt=Rdy=1 -> exactly one WEn with Cntl=CNTL_IDLE and Data=0x00; then Req=0 and the block idles in CHK.
- directControlEn=1 with line state 2'b01, then 2'b10 after 3 writes, Gnt/Rdy=1 -> WEn pulses every 2 cycles with Data 0x01 (x3), then 0x02; dropping En -> one idle write, then Req=0.
- timedStart with timedCount=5, line 2'b00 -> exactly 5 direct writes of Data 0x00, one idle write, timedDone pulse of 1 cycle, timedBusy high throughout; timedCount=0 -> exactly 1 direct write.
- timedStart and directControlEn high in the same cycle -> timed session runs first (directControlEn ignored throughout it); afterwards a direct session starts.
- Rdy toggled low for 4 cycles mid-timed-session -> no WEn while Rdy=0; write count is still exactly N.
- rst asserted in T_LOOP -> all outputs 0 next cycle, no timedDone, no further writes.
